// File: rtl/clz_pkg.sv
// Shared types and elaboration helpers for the CLZ normalization controller.
package clz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } clz_norm_state_t;

    localparam int LEGAL_WIDTH_A = 32;
    localparam int LEGAL_WIDTH_B = 24;

    function automatic bit is_legal_width(input int w);
        return (w == LEGAL_WIDTH_A) || (w == LEGAL_WIDTH_B);
    endfunction

endpackage

// File: rtl/clz_normalize_ctrl_if.sv
// Operand/exponent request and normalized result channels of the controller.
interface clz_normalize_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8
);
    localparam int LZW = $clog2(DATA_WIDTH);

    // Both channels: a beat moves on a rising edge where valid and ready are both 1;
    // the producer holds valid and payload stable until then and valid never waits on ready.
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] operand_i;
    logic [EXP_WIDTH-1:0]  exp_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] result_o;
    logic [EXP_WIDTH-1:0]  exp_o;
    logic [LZW-1:0]        lz_count_o;
    logic                  zero_o;
    logic                  denorm_o;

    modport slave (
        input  valid_i, operand_i, exp_i, ready_i,
        output ready_o, valid_o, result_o, exp_o, lz_count_o, zero_o, denorm_o
    );

    modport master (
        output valid_i, operand_i, exp_i, ready_i,
        input  ready_o, valid_o, result_o, exp_o, lz_count_o, zero_o, denorm_o
    );
endinterface

// File: rtl/clz_normalize_ctrl_clz.sv
// Combinational leading-zero counter; the count is meaningless for an all-zero input.
module count_leading_zeros #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic [$clog2(DATA_WIDTH)-1:0] count_o
);
    localparam int LZW = $clog2(DATA_WIDTH);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data_i[i]) count_o = LZW'(DATA_WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/clz_normalize_ctrl.sv
// Normalization controller: count leading zeros, then left-justify the operand
// limited by the exponent, reporting zero and denormal outcomes.
module clz_normalize_ctrl
    import clz_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    clz_normalize_ctrl_if.slave    bus,
    output clz_norm_state_t        state_o
);
    localparam int LZW         = $clog2(DATA_WIDTH);
    localparam int CW          = (EXP_WIDTH > LZW) ? EXP_WIDTH : LZW;
    localparam int ZERO_LZ_INT = (DATA_WIDTH > (2**LZW) - 1) ? (2**LZW) - 1 : DATA_WIDTH;
    localparam logic [LZW-1:0] ZERO_LZ = LZW'(ZERO_LZ_INT);

    if (!is_legal_width(DATA_WIDTH)) begin : g_bad_width
        $error("clz_normalize_ctrl: DATA_WIDTH must be 32 or 24");
    end

    clz_norm_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [LZW-1:0]        lz_q, lz_d;
    logic                  zero_q, zero_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [EXP_WIDTH-1:0]  exp_res_q, exp_res_d;
    logic [LZW-1:0]        lz_out_q, lz_out_d;
    logic                  zero_out_q, zero_out_d;
    logic                  denorm_q, denorm_d;
    logic                  valid_q, valid_d;

    logic [LZW-1:0] clz_count;
    logic           exp_lt_lz;
    logic [CW-1:0]  shamt;

    count_leading_zeros #(.DATA_WIDTH(DATA_WIDTH)) u_clz (
        .data_i  (operand_q),
        .count_o (clz_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus.valid_i ? COUNT : IDLE;
            COUNT:   state_d = SHIFT;
            SHIFT:   state_d = DONE;
            DONE:    state_d = (valid_q && bus.ready_i) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = (state_q == IDLE);
        state_o     = state_q;
    end

    // Shift is capped by the exponent so the adjusted exponent cannot underflow.
    assign exp_lt_lz = CW'(exp_q) < CW'(lz_q);
    assign shamt     = exp_lt_lz ? CW'(exp_q) : CW'(lz_q);

    always_comb begin
        operand_d  = operand_q;
        exp_d      = exp_q;
        lz_d       = lz_q;
        zero_d     = zero_q;
        res_d      = res_q;
        exp_res_d  = exp_res_q;
        lz_out_d   = lz_out_q;
        zero_out_d = zero_out_q;
        denorm_d   = denorm_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    operand_d = bus.operand_i;
                    exp_d     = bus.exp_i;
                end
            end
            COUNT: begin
                zero_d = ~|operand_q;
                lz_d   = (~|operand_q) ? ZERO_LZ : clz_count;
            end
            SHIFT: begin
                lz_out_d = lz_q;
                if (zero_q) begin
                    res_d      = '0;
                    exp_res_d  = '0;
                    zero_out_d = 1'b1;
                    denorm_d   = 1'b0;
                end else begin
                    res_d      = operand_q << shamt;
                    exp_res_d  = exp_q - EXP_WIDTH'(shamt);
                    zero_out_d = 1'b0;
                    denorm_d   = exp_lt_lz;
                end
            end
            default: ;
        endcase
        valid_d = (state_q == DONE) && !(valid_q && bus.ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            operand_q  <= '0;
            exp_q      <= '0;
            lz_q       <= '0;
            zero_q     <= 1'b0;
            res_q      <= '0;
            exp_res_q  <= '0;
            lz_out_q   <= '0;
            zero_out_q <= 1'b0;
            denorm_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            operand_q  <= operand_d;
            exp_q      <= exp_d;
            lz_q       <= lz_d;
            zero_q     <= zero_d;
            res_q      <= res_d;
            exp_res_q  <= exp_res_d;
            lz_out_q   <= lz_out_d;
            zero_out_q <= zero_out_d;
            denorm_q   <= denorm_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.result_o   = res_q;
    assign bus.exp_o      = exp_res_q;
    assign bus.lz_count_o = lz_out_q;
    assign bus.zero_o     = zero_out_q;
    assign bus.denorm_o   = denorm_q;
endmodule
